// File: rtl/stage3.sv
// stage3: multi-round final exam scoring the stage-2 verdict into pass3/grade/total.
// Optional second exam for a first-pass failure when STAGE3_RETRY_EN is defined.
module stage3 #(
  parameter int ROUNDS  = 4,
  parameter int PASS_TH = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pass2,
  input  logic [1:0] bonus2,
  input  logic [6:0] effort,
  input  logic [4:0] hard,
  input  logic [6:0] random3,
  input  logic       ack,
  output logic       busy,
  output logic       done,
  output logic       pass3,
  output logic [1:0] grade,
  output logic [7:0] total,
  output logic       retry_used
);
  typedef enum logic [1:0] {IDLE, EXAM, SCORE, RESULT} state_t;
  state_t state, state_n;
  logic [7:0] acc, t;
  logic [3:0] rnd, eff_hi;
  logic [1:0] bonus_c, grade_n;
  logic [4:0] hard_c;
  logic       pass2_c, pass_n, retry_go, unused_bits;
  always_comb begin
    t = (acc > {3'b0, hard_c}) ? acc - {3'b0, hard_c} : 8'd0;
    pass_n = t >= 8'(PASS_TH);
    grade_n = (t >= 8'd80) ? 2'd3 : (t >= 8'd64) ? 2'd2 : pass_n ? 2'd1 : 2'd0;
`ifdef STAGE3_RETRY_EN
    retry_go = !pass_n && pass2_c && !retry_used;
`else
    retry_go = 1'b0;
`endif
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? (pass2 ? EXAM : RESULT) : IDLE;
      EXAM:    state_n = (rnd == 4'(ROUNDS - 1)) ? SCORE : EXAM;
      SCORE:   state_n = retry_go ? EXAM : RESULT;
      RESULT:  state_n = (done && ack) ? IDLE : RESULT;
      default: state_n = IDLE;
    endcase
  end
  always_comb busy = state != IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      acc <= '0;
      rnd <= '0;
      bonus_c <= '0;
      eff_hi <= '0;
      hard_c <= '0;
      pass2_c <= 1'b0;
      done <= 1'b0;
      pass3 <= 1'b0;
      grade <= '0;
      total <= '0;
    end else
      case (state)
        IDLE: if (start) begin
          pass2_c <= pass2;
          bonus_c <= bonus2;
          eff_hi <= effort[6:3];
          hard_c <= hard;
          done <= 1'b0;
          rnd <= '0;
          acc <= pass2 ? {3'b0, bonus2, 3'b0} : 8'd0;
          if (!pass2) begin
            pass3 <= 1'b0;
            grade <= '0;
            total <= '0;
          end
        end
        EXAM: begin
          acc <= acc + {4'b0, eff_hi} + {6'b0, random3[1:0]};
          rnd <= rnd + 4'd1;
        end
        SCORE: if (retry_go) begin
          acc <= {3'b0, bonus_c, 3'b0};
          rnd <= '0;
        end else begin
          total <= t;
          pass3 <= pass_n;
          grade <= grade_n;
          done <= 1'b1;
        end
        // the skip path arrives with done low; it rises one edge later
        RESULT: done <= !(done && ack);
        default: ;
      endcase
`ifdef STAGE3_RETRY_EN
  always_ff @(posedge clk)
    if (rst) retry_used <= 1'b0;
    else if (state == IDLE && start) retry_used <= 1'b0;
    else if (state == SCORE && retry_go) retry_used <= 1'b1;
  assign unused_bits = ^random3[6:2];
`else
  assign retry_used = 1'b0;
  assign unused_bits = ^{random3[6:2], pass2_c};
`endif
endmodule
